// File: rtl/branch_predictor.sv
// Direct-mapped branch predictor: per-entry tag, target and saturating counter.
// Zero-latency fetch lookup, execute-stage training and branch/miss counters.
//
// Ports:
//   clk, rst            clock; asynchronous active-low reset
//   pred_en             1 = dynamic prediction, 0 = static not-taken
//   f_pc                fetch PC to look up
//   predict_taken       redirect fetch to predict_target
//   predict_target      entry target on hit, else f_pc + 4
//   predict_hit         f_pc matches a valid entry
//   upd_valid           a conditional branch resolves this cycle
//   upd_pc              PC of the resolved branch
//   upd_taken           resolved outcome
//   upd_target          resolved target
//   upd_mispredict      prediction used for this branch was wrong
//   branch_cnt          saturating count of resolved branches
//   miss_cnt            saturating count of mispredictions
module branch_predictor #(
    parameter int ENTRIES = 16,
    parameter int CTR_W   = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pred_en,
    input  logic [31:0] f_pc,
    output logic        predict_taken,
    output logic [31:0] predict_target,
    output logic        predict_hit,
    input  logic        upd_valid,
    input  logic [31:0] upd_pc,
    input  logic        upd_taken,
    input  logic [31:0] upd_target,
    input  logic        upd_mispredict,
    output logic [31:0] branch_cnt,
    output logic [31:0] miss_cnt
);

    localparam int IDX_W = $clog2(ENTRIES);
    localparam int TAG_W = 30 - IDX_W;

    localparam logic [CTR_W-1:0] CTR_MAX  = {CTR_W{1'b1}};
    localparam logic [CTR_W-1:0] CTR_WEAK = CTR_W'(1 << (CTR_W - 1));

    logic             valid_q [ENTRIES];
    logic [TAG_W-1:0] tag_q   [ENTRIES];
    logic [31:0]      tgt_q   [ENTRIES];
    logic [CTR_W-1:0] ctr_q   [ENTRIES];

    logic [IDX_W-1:0] f_idx;
    logic [TAG_W-1:0] f_tag;
    logic [IDX_W-1:0] u_idx;
    logic [TAG_W-1:0] u_tag;
    logic             u_hit;
    logic [CTR_W-1:0] u_ctr;

    // Byte offset bits never select an entry.
    logic unused_pc_lsb;
    assign unused_pc_lsb = ^{f_pc[1:0], upd_pc[1:0]};

    assign f_idx = f_pc[IDX_W+1:2];
    assign f_tag = f_pc[31:IDX_W+2];
    assign u_idx = upd_pc[IDX_W+1:2];
    assign u_tag = upd_pc[31:IDX_W+2];

    // Lookup reads the stored state only, so a same-cycle update to the
    // same index is seen from the next cycle on.
    always_comb begin
        predict_hit    = 1'b0;
        predict_taken  = 1'b0;
        predict_target = f_pc + 32'd4;
        if (rst && valid_q[f_idx] && (tag_q[f_idx] == f_tag)) begin
            predict_hit    = 1'b1;
            predict_target = tgt_q[f_idx];
            predict_taken  = pred_en & ctr_q[f_idx][CTR_W-1];
        end
    end

    assign u_hit = valid_q[u_idx] && (tag_q[u_idx] == u_tag);
    assign u_ctr = ctr_q[u_idx];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i] <= 1'b0;
                tag_q[i]   <= '0;
                tgt_q[i]   <= '0;
                ctr_q[i]   <= '0;
            end
        end else if (upd_valid) begin
            if (u_hit) begin
                if (upd_taken) begin
                    if (u_ctr != CTR_MAX) begin
                        ctr_q[u_idx] <= u_ctr + CTR_W'(1);
                    end
                    tgt_q[u_idx] <= upd_target;
                end else if (u_ctr != '0) begin
                    ctr_q[u_idx] <= u_ctr - CTR_W'(1);
                end
            end else if (upd_taken) begin
                // Direct-mapped: a taken miss evicts whatever lives here.
                valid_q[u_idx] <= 1'b1;
                tag_q[u_idx]   <= u_tag;
                tgt_q[u_idx]   <= upd_target;
                ctr_q[u_idx]   <= CTR_WEAK;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            branch_cnt <= '0;
            miss_cnt   <= '0;
        end else if (upd_valid) begin
            if (branch_cnt != '1) begin
                branch_cnt <= branch_cnt + 32'd1;
            end
            if (upd_mispredict && (miss_cnt != '1)) begin
                miss_cnt <= miss_cnt + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_branch_predictor.sv
// Testbench for branch_predictor (ENTRIES = 16, CTR_W = 2): directed
// scenarios followed by random traffic against a behavioural table model.
module tb_branch_predictor;

    logic        clk = 1'b0;
    logic        rst;
    logic        pred_en;
    logic [31:0] f_pc;
    logic        predict_taken;
    logic [31:0] predict_target;
    logic        predict_hit;
    logic        upd_valid;
    logic [31:0] upd_pc;
    logic        upd_taken;
    logic [31:0] upd_target;
    logic        upd_mispredict;
    logic [31:0] branch_cnt;
    logic [31:0] miss_cnt;

    int n_checks = 0;
    int n_errors = 0;

    branch_predictor #(.ENTRIES(16), .CTR_W(2)) dut (
        .clk(clk), .rst(rst), .pred_en(pred_en), .f_pc(f_pc),
        .predict_taken(predict_taken), .predict_target(predict_target),
        .predict_hit(predict_hit), .upd_valid(upd_valid), .upd_pc(upd_pc),
        .upd_taken(upd_taken), .upd_target(upd_target),
        .upd_mispredict(upd_mispredict), .branch_cnt(branch_cnt),
        .miss_cnt(miss_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference model: 16 slots keyed by (pc/4) mod 16, tag = pc/64.
    bit          m_valid [16];
    int unsigned m_tag   [16];
    logic [31:0] m_tgt   [16];
    int          m_ctr   [16];
    longint      m_bcnt;
    longint      m_mcnt;

    function automatic int slot(logic [31:0] pc);
        return int'((pc / 4) % 16);
    endfunction

    function automatic bit m_hit(logic [31:0] pc);
        return m_valid[slot(pc)] && (m_tag[slot(pc)] == pc / 64);
    endfunction

    function automatic logic [31:0] sat32(longint v);
        return (v > 64'hFFFF_FFFF) ? 32'hFFFF_FFFF : v[31:0];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 16; i++) begin
            m_valid[i] = 0;
            m_tag[i]   = 0;
            m_tgt[i]   = '0;
            m_ctr[i]   = 0;
        end
        m_bcnt = 0;
        m_mcnt = 0;
    endtask

    task automatic model_update();
        int s;
        if (!upd_valid) return;
        s = slot(upd_pc);
        m_bcnt++;
        if (upd_mispredict) m_mcnt++;
        if (m_hit(upd_pc)) begin
            if (upd_taken) begin
                m_ctr[s] = (m_ctr[s] + 1 > 3) ? 3 : m_ctr[s] + 1;
                m_tgt[s] = upd_target;
            end else begin
                m_ctr[s] = (m_ctr[s] - 1 < 0) ? 0 : m_ctr[s] - 1;
            end
        end else if (upd_taken) begin
            m_valid[s] = 1;
            m_tag[s]   = upd_pc / 64;
            m_tgt[s]   = upd_target;
            m_ctr[s]   = 2;
        end
    endtask

    task automatic check_model(string tag);
        bit          h;
        logic [31:0] t;
        h = m_hit(f_pc);
        t = h ? m_tgt[slot(f_pc)] : f_pc + 4;
        check({tag, ".hit"}, 32'(predict_hit), 32'(h));
        check({tag, ".taken"}, 32'(predict_taken),
              32'(pred_en && h && m_ctr[slot(f_pc)] >= 2));
        check({tag, ".target"}, predict_target, t);
        check({tag, ".bcnt"}, branch_cnt, sat32(m_bcnt));
        check({tag, ".mcnt"}, miss_cnt, sat32(m_mcnt));
    endtask

    task automatic apply(string tag, logic pe, logic [31:0] fpc, logic uv,
                         logic [31:0] upc, logic ut, logic [31:0] utgt,
                         logic um);
        @(negedge clk);
        pred_en        = pe;
        f_pc           = fpc;
        upd_valid      = uv;
        upd_pc         = upc;
        upd_taken      = ut;
        upd_target     = utgt;
        upd_mispredict = um;
        #1;
        check_model(tag);
    endtask

    task automatic commit();
        @(posedge clk);
        if (rst) model_update();
    endtask

    task automatic cyc(string tag, logic [31:0] fpc, logic uv,
                       logic [31:0] upc, logic ut, logic [31:0] utgt,
                       logic um);
        apply(tag, 1'b1, fpc, uv, upc, ut, utgt, um);
        commit();
    endtask

    initial begin
        logic [31:0] a, b;
        rst = 1'b0;
        pred_en = 1'b1;
        f_pc = 32'h100;
        upd_valid = 1'b0;
        upd_pc = '0;
        upd_taken = 1'b0;
        upd_target = '0;
        upd_mispredict = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("rst.hit", 32'(predict_hit), 32'd0);
        check("rst.taken", 32'(predict_taken), 32'd0);
        check("rst.target", predict_target, 32'h104);
        check("rst.bcnt", branch_cnt, 32'd0);
        check("rst.mcnt", miss_cnt, 32'd0);

        // Allocate, then hit with weakly-taken counter.
        cyc("alloc", 32'h100, 1, 32'h100, 1, 32'h80, 0);
        apply("hit", 1, 32'h100, 0, 0, 0, 0, 0);
        check("hit.taken_c", 32'(predict_taken), 32'd1);
        check("hit.target_c", predict_target, 32'h80);
        check("hit.bcnt_c", branch_cnt, 32'd1);
        commit();

        // Counter walks down and saturates at 0, then up to 3.
        repeat (3) cyc("nt", 32'h100, 1, 32'h100, 0, 32'h0, 0);
        apply("nt.end", 1, 32'h100, 0, 0, 0, 0, 0);
        check("nt.taken_c", 32'(predict_taken), 32'd0);
        check("nt.hit_c", 32'(predict_hit), 32'd1);
        commit();
        repeat (4) cyc("tk", 32'h100, 1, 32'h100, 1, 32'h80, 0);
        cyc("tk.end", 32'h100, 0, 0, 0, 0, 0);

        // One not-taken from saturation must still predict taken.
        cyc("sat", 32'h100, 1, 32'h100, 0, 0, 0);
        apply("sat.chk", 1, 32'h100, 0, 0, 0, 0, 0);
        check("sat.taken_c", 32'(predict_taken), 32'd1);
        commit();

        // Conflicting tag evicts the old entry.
        cyc("evict", 32'h140, 1, 32'h140, 1, 32'h200, 0);
        apply("ev.old", 1, 32'h100, 0, 0, 0, 0, 0);
        check("ev.old_hit_c", 32'(predict_hit), 32'd0);
        commit();
        apply("ev.new", 1, 32'h140, 0, 0, 0, 0, 0);
        check("ev.new_tgt_c", predict_target, 32'h200);
        commit();

        // Static mode and miss counting.
        cyc("strong", 32'h140, 1, 32'h140, 1, 32'h200, 0);
        for (int i = 0; i < 5; i++) begin
            apply("static", 0, 32'h140, 1, 32'h140, 1, 32'h200, 1);
            check("static.taken_c", 32'(predict_taken), 32'd0);
            check("static.hit_c", 32'(predict_hit), 32'd1);
            commit();
        end
        apply("mcnt", 1, 32'h140, 0, 0, 0, 0, 1);
        check("mcnt.c", miss_cnt, 32'd5);
        commit();

        // Mid-cycle reset with an update pulse held across an edge.
        @(posedge clk);
        #2;
        rst = 1'b0;
        upd_valid = 1'b1;
        upd_pc = 32'h180;
        upd_taken = 1'b1;
        upd_target = 32'h300;
        f_pc = 32'h140;
        #1;
        model_reset();
        check("mid.hit", 32'(predict_hit), 32'd0);
        check("mid.target", predict_target, 32'h144);
        check("mid.bcnt", branch_cnt, 32'd0);
        check("mid.mcnt", miss_cnt, 32'd0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        upd_valid = 1'b0;
        #1;
        f_pc = 32'h180;
        #1;
        check("post.hit", 32'(predict_hit), 32'd0);
        check("post.bcnt", branch_cnt, 32'd0);

        // First edge after release accepts an update.
        cyc("first", 32'h180, 1, 32'h180, 1, 32'h300, 0);
        cyc("first.chk", 32'h180, 0, 0, 0, 0, 0);

        // Random traffic over a small PC pool to force hits and conflicts.
        for (int n = 0; n < 500; n++) begin
            a = ($urandom_range(0, 3) << 6) | ($urandom_range(0, 15) << 2)
                | $urandom_range(0, 3);
            b = ($urandom_range(0, 3) << 6) | ($urandom_range(0, 15) << 2)
                | $urandom_range(0, 3);
            if ($urandom_range(0, 3) == 0) b = a;
            apply("rnd", 1'($urandom_range(0, 7) != 0), a,
                  1'($urandom_range(0, 3) != 0), b, 1'($urandom),
                  $urandom, 1'($urandom));
            commit();
        end
        apply("rnd.end", 1, 32'h0, 0, 0, 0, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/branch_predictor.md
BRANCH_PREDICTOR -- requirements
Module: branch_predictor

Interface
REQ-001 Parameter: ENTRIES, default 16, number of table entries; power of two, 2..256.
REQ-002 Parameter: CTR_W, default 2, saturating counter width, 1..4.
REQ-003 Port: clk  input  1  single clock; all state updates on its rising edge.
REQ-004 Port: rst  input  1  reset; asynchronous assert and active-low (0 = reset).
REQ-005 Port: pred_en  input  1  1 = dynamic prediction; 0 = static not-taken mode.
REQ-006 Port: f_pc  input  32  fetch-stage PC to predict.
REQ-007 Port: predict_taken  output  1  predict redirect of fetch.
REQ-008 Port: predict_target  output  32  predicted next PC when predict_taken = 1.
REQ-009 Port: predict_hit  output  1  f_pc matches a valid entry.
REQ-010 Port: upd_valid  input  1  execute stage resolves a conditional branch this cycle.
REQ-011 Port: upd_pc  input  32  PC of the resolved branch.
REQ-012 Port: upd_taken  input  1  actual branch outcome.
REQ-013 Port: upd_target  input  32  actual branch target (pc + imm).
REQ-014 Port: upd_mispredict  input  1  prediction used for this branch was wrong; qualified by upd_valid.
REQ-015 Port: branch_cnt  output  32  resolved-branch count.
REQ-016 Port: miss_cnt  output  32  misprediction count.

Function
REQ-017 IDX_W = log2(ENTRIES); index = pc[IDX_W+1:2]; tag = pc[31:IDX_W+2]; pc[1:0] ignored.
REQ-018 Each entry holds valid, tag, target[31:0] and counter[CTR_W-1:0].
REQ-019 Lookup is combinational, zero latency: predict_hit = valid & tag match at f_pc index.
REQ-020 predict_taken = pred_en & predict_hit & counter MSB; predict_target = entry target on hit, else f_pc + 4.
REQ-021 When pred_en = 0, predict_taken = 0; table updates and counters still operate.
REQ-022 Update on rising clk when upd_valid = 1 only; upd_* ignored otherwise.
REQ-023 Update hit, taken: counter saturating +1 (max 2^CTR_W-1); target <= upd_target.
REQ-024 Update hit, not taken: counter saturating -1 (min 0); target unchanged; entry stays valid.
REQ-025 Update miss, taken: allocate at index (direct-mapped, overwrite any occupant): valid=1, tag, target=upd_target, counter = 2^(CTR_W-1) (weakly taken).
REQ-026 Update miss, not taken: no table change.
REQ-027 Same-cycle lookup and update to same index: lookup returns pre-update contents; no bypass.
REQ-028 branch_cnt +1 per upd_valid cycle; miss_cnt +1 per upd_valid & upd_mispredict cycle; both saturate at 0xFFFFFFFF, never wrap.
REQ-029 upd_mispredict with upd_valid = 0 has no effect.

Reset
REQ-030 rst = 0 asynchronously clears all valid bits, counters to 0, targets to 0, branch_cnt = 0, miss_cnt = 0, without waiting for clk.
REQ-031 During reset: predict_hit = 0, predict_taken = 0, predict_target = f_pc + 4.
REQ-032 Reset asserted mid-update discards that update; first update is accepted at the first rising clk with rst = 1.

Verification
REQ-033 Post reset, f_pc = 0x100 -> predict_hit = 0, predict_taken = 0, predict_target = 0x104, both counts = 0.
REQ-034 Update pc 0x100 taken target 0x80, then f_pc = 0x100 -> hit = 1, taken = 1 (counter 2), target = 0x80; branch_cnt = 1.
REQ-035 Same entry: 3 not-taken updates -> counter 2->1->0->0, predict_taken = 0 after first; 4 taken updates -> counter saturates at 3.
REQ-036 ENTRIES = 16: allocate 0x100 taken, then 0x140 taken (same index, different tag) -> f_pc = 0x100 misses, f_pc = 0x140 hits with its own target.
REQ-037 pred_en = 0 with valid strongly-taken entry -> predict_taken = 0, predict_hit = 1; 5 updates with upd_mispredict = 1 -> miss_cnt = 5.
REQ-038 Assert rst = 0 between clk edges with entries populated -> outputs clear immediately; an upd_valid pulse during reset leaves table empty after release.
